abs_diff_pipe: RTL and testbench

- Pipelined, multi-lane successor to the combinational single-pair absolute-difference unit used for green-gradient estimation in the CFA interpolation path.
- Each accepted beat carries LANES pixel pairs. The block returns each exact per-lane |a-b|.
- It also accumulates a sum of absolute differences (SAD) over a WIN_LEN-beat window, for the direction decision logic downstream.
- Streams with valid/ready handshakes on both sides.

---
 rtl/abs_diff_pipe.sv | 157 +++++++++++++++
 tb/tb_abs_diff_pipe.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/abs_diff_pipe.sv
// abs_diff_pipe: two-stage, multi-lane absolute-difference pipeline with a
// windowed sum of absolute differences (SAD) for gradient direction decisions.
//
// Stage 1 registers the signed per-lane difference a-b (PIXEL_W+1 bits).
// Stage 2 registers the per-lane magnitude and folds the beat into the SAD
// window accumulator; sad_last marks the beat that closes a window.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. The producer holds data stable while valid && !ready. in_ready drops
// whenever the output register is full and not being drained, and during a
// win_clr cycle so no beat is accepted and then flushed.
//
// Optional build macro ABS_DIFF_CLIP_EN: saturate every lane magnitude to
// 2^(PIXEL_W-1)-1 before output and accumulation. Undefined: full precision.
module abs_diff_pipe #(
    parameter int PIXEL_W = 14,
    parameter int LANES   = 2,
    parameter int WIN_LEN = 5,
    localparam int SAD_W  = PIXEL_W + $clog2(LANES * WIN_LEN)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [LANES*PIXEL_W-1:0]   a_in,
    input  logic [LANES*PIXEL_W-1:0]   b_in,
    input  logic                       win_clr,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [LANES*PIXEL_W-1:0]   diff_out,
    output logic [SAD_W-1:0]           sad_out,
    output logic                       sad_last
);

    localparam int DW    = PIXEL_W + 1;
    localparam int CNT_W = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIN_LEN - 1);
`ifdef ABS_DIFF_CLIP_EN
    localparam logic [PIXEL_W-1:0] CLIP_MAX = {1'b0, {(PIXEL_W-1){1'b1}}};
`endif

    // Pipeline state
    logic                       s1_valid_q, s1_valid_d;
    logic [LANES*DW-1:0]        d_q, d_d;
    logic                       out_valid_q, out_valid_d;
    logic [LANES*PIXEL_W-1:0]   diff_q, diff_d;
    logic [SAD_W-1:0]           sad_q, sad_d;
    logic                       sad_last_q, sad_last_d;
    logic [SAD_W-1:0]           acc_q, acc_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;

    // Combinational helpers
    logic                       en;
    logic                       accept;
    logic [LANES*DW-1:0]        d_new;
    logic [LANES*PIXEL_W-1:0]   m;
    logic [SAD_W-1:0]           beat_sum;

    assign en        = !out_valid_q || out_ready;
    assign in_ready  = en && !win_clr;
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign diff_out  = diff_q;
    assign sad_out   = sad_q;
    assign sad_last  = sad_last_q;

    // Stage-1 arithmetic: zero-extended operands, signed difference per lane.
    always_comb begin
        d_new = '0;
        for (int k = 0; k < LANES; k++) begin
            d_new[k*DW +: DW] = {1'b0, a_in[k*PIXEL_W +: PIXEL_W]}
                              - {1'b0, b_in[k*PIXEL_W +: PIXEL_W]};
        end
    end

    // Stage-2 arithmetic: magnitude of each registered difference, plus the
    // sum over lanes. |d| < 2^PIXEL_W, so negating only the low PIXEL_W bits
    // is exact.
    always_comb begin
        m        = '0;
        beat_sum = '0;
        for (int k = 0; k < LANES; k++) begin
            logic [PIXEL_W-1:0] mag;
            mag = d_q[k*DW + PIXEL_W] ? (~d_q[k*DW +: PIXEL_W] + 1'b1)
                                      : d_q[k*DW +: PIXEL_W];
`ifdef ABS_DIFF_CLIP_EN
            if (mag > CLIP_MAX) begin
                mag = CLIP_MAX;
            end
`endif
            m[k*PIXEL_W +: PIXEL_W] = mag;
            beat_sum = beat_sum + SAD_W'(mag);
        end
    end

    // Next-state: win_clr flushes unconditionally, otherwise advance when en.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        d_d         = d_q;
        out_valid_d = out_valid_q;
        diff_d      = diff_q;
        sad_d       = sad_q;
        sad_last_d  = sad_last_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        if (win_clr) begin
            s1_valid_d  = 1'b0;
            out_valid_d = 1'b0;
            sad_last_d  = 1'b0;
            acc_d       = '0;
            cnt_d       = '0;
        end else if (en) begin
            s1_valid_d  = accept;
            if (accept) begin
                d_d = d_new;
            end
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                diff_d = m;
                if (cnt_q == CNT_LAST) begin
                    sad_d      = acc_q + beat_sum;
                    sad_last_d = 1'b1;
                    acc_d      = '0;
                    cnt_d      = '0;
                end else begin
                    acc_d      = acc_q + beat_sum;
                    cnt_d      = cnt_q + 1'b1;
                    sad_last_d = 1'b0;
                end
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            d_q         <= '0;
            out_valid_q <= 1'b0;
            diff_q      <= '0;
            sad_q       <= '0;
            sad_last_q  <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            d_q         <= d_d;
            out_valid_q <= out_valid_d;
            diff_q      <= diff_d;
            sad_q       <= sad_d;
            sad_last_q  <= sad_last_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule

// File: tb/tb_abs_diff_pipe.sv
// tb_abs_diff_pipe: directed and randomized checks of abs_diff_pipe
// (PIXEL_W=14, LANES=2, WIN_LEN=4) against a beat-level reference model.
// Build with ABS_DIFF_CLIP_EN defined to check the clipped variant.
module tb_abs_diff_pipe;

    localparam int PW   = 14;
    localparam int LN   = 2;
    localparam int WL   = 4;
    localparam int SW   = PW + $clog2(LN * WL);
    localparam int PMAX = (1 << PW) - 1;
`ifdef ABS_DIFF_CLIP_EN
    localparam int MMAX = (1 << (PW - 1)) - 1;
`else
    localparam int MMAX = PMAX;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [LN*PW-1:0]  a_in = '0;
    logic [LN*PW-1:0]  b_in = '0;
    logic              win_clr = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [LN*PW-1:0]  diff_out;
    logic [SW-1:0]     sad_out;
    logic              sad_last;

    abs_diff_pipe #(.PIXEL_W(PW), .LANES(LN), .WIN_LEN(WL)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a_in(a_in), .b_in(b_in), .win_clr(win_clr), .out_valid(out_valid),
        .out_ready(out_ready), .diff_out(diff_out), .sad_out(sad_out),
        .sad_last(sad_last)
    );

    // Clock
    always #5 clk = ~clk;

    // Counters and scoreboard state
    int n_assert = 0;
    int n_fail   = 0;
    logic [2*LN*PW-1:0] exp_q[$];   // {a_in, b_in} of each accepted beat
    int m_cnt = 0, m_acc = 0;       // reference window position and sum
    int n_out = 0, n_last = 0, last_sad = 0;
    logic              hold_v = 1'b0;
    logic [LN*PW-1:0]  hold_diff;
    logic [SW-1:0]     hold_sad;
    logic              hold_last;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int mag(input int a, input int b);
        int d;
        d = (a > b) ? a - b : b - a;
        return (d > MMAX) ? MMAX : d;
    endfunction

    function automatic logic [PW-1:0] rpix();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return PW'(PMAX);
            default: return PW'($urandom_range(0, PMAX));
        endcase
    endfunction

    // Monitor / scoreboard, sampled on the falling edge.
    logic [2*LN*PW-1:0] item;
    int e0, e1, exp_sad;
    logic exp_last;
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            m_cnt  = 0;
            m_acc  = 0;
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                check("stall_valid", 32'(out_valid), 1);
                check("stall_diff", 32'(diff_out), 32'(hold_diff));
                check("stall_sad", 32'(sad_out), 32'(hold_sad));
                check("stall_last", 32'(sad_last), 32'(hold_last));
            end
            if (out_valid && out_ready) begin
                n_out++;
                if (sad_last) begin
                    n_last++;
                    last_sad = int'(sad_out);
                end
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 0, 1);
                end else begin
                    item = exp_q.pop_front();
                    e0 = mag(int'(item[2*PW +: PW]), int'(item[0 +: PW]));
                    e1 = mag(int'(item[3*PW +: PW]), int'(item[PW +: PW]));
                    if (m_cnt == WL - 1) begin
                        exp_last = 1'b1;
                        exp_sad  = m_acc + e0 + e1;
                        m_acc    = 0;
                        m_cnt    = 0;
                    end else begin
                        exp_last = 1'b0;
                        exp_sad  = 0;
                        m_acc    = m_acc + e0 + e1;
                        m_cnt    = m_cnt + 1;
                    end
                    check("diff_lane0", 32'(diff_out[0 +: PW]), e0);
                    check("diff_lane1", 32'(diff_out[PW +: PW]), e1);
                    check("sad_last", 32'(sad_last), 32'(exp_last));
                    if (exp_last) check("sad_out", 32'(sad_out), exp_sad);
                end
            end
            if (in_valid && in_ready) exp_q.push_back({a_in, b_in});
            if (win_clr) begin
                exp_q.delete();
                m_cnt = 0;
                m_acc = 0;
            end
            hold_v    = out_valid && !out_ready && !win_clr;
            hold_diff = diff_out;
            hold_sad  = sad_out;
            hold_last = sad_last;
        end
    end

    // Driver tasks
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_accept();
        int t;
        t = 0;
        while (1) begin
            @(negedge clk);
            if (in_ready) break;
            t++;
            if (t > 100) begin
                check("accept_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drive(input int a0, input int b0, input int a1, input int b1);
        a_in     = {PW'(a1), PW'(a0)};
        b_in     = {PW'(b1), PW'(b0)};
        in_valid = 1'b1;
    endtask

    task automatic send(input int a0, input int b0, input int a1, input int b1);
        drive(a0, b0, a1, b1);
        wait_accept();
    endtask

    task automatic pulse_clr();
        win_clr = 1'b1;
        @(posedge clk);
        #1;
        win_clr = 1'b0;
    endtask

    int nl0, no0;

    initial begin
        // Reset state
        idle(2);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_diff", 32'(diff_out), 0);
        check("rst_sad", 32'(sad_out), 0);
        check("rst_last", 32'(sad_last), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 1);

        // Exactness and two-cycle latency
        @(posedge clk);
        #1;
        drive(100, 40, 0, 16383);
        @(negedge clk);
        check("exact_in_ready", 32'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("lat_early", 32'(out_valid), 0);
        @(negedge clk);
        check("lat_valid", 32'(out_valid), 1);
        check("exact_lane0", 32'(diff_out[0 +: PW]), 60);
        check("exact_lane1", 32'(diff_out[PW +: PW]), MMAX);
        @(posedge clk);
        #1;
        pulse_clr();

        // One full window of diffs 10 and 20, then a fresh window
        nl0 = n_last;
        repeat (4) send(50, 40, 5, 25);
        idle(3);
        check("win_count", 32'(n_last - nl0), 1);
        check("win_sad", 32'(last_sad), 120);
        send(7, 6, 3, 4);
        idle(3);
        check("win_fresh", 32'(n_last - nl0), 1);

        // Backpressure: output held, input stalls, order kept
        out_ready = 1'b0;
        send(1000, 10, 20, 3000);
        send(5, 16383, 16383, 5);
        drive(1, 2, 3, 4);
        @(negedge clk);
        check("bp_in_ready_a", 32'(in_ready), 0);
        @(negedge clk);
        check("bp_in_ready_b", 32'(in_ready), 0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_accept();
        idle(4);

        // win_clr drops two in-flight beats, next window sums to 8
        out_ready = 1'b0;
        send(9, 2, 2, 9);
        send(4, 4, 0, 0);
        pulse_clr();
        out_ready = 1'b1;
        nl0 = n_last;
        no0 = n_out;
        idle(2);
        check("clr_no_out", 32'(n_out - no0), 0);
        repeat (4) send(7, 6, 3, 4);
        idle(3);
        check("clr_count", 32'(n_last - nl0), 1);
        check("clr_sad", 32'(last_sad), 8);

        // Randomized traffic with backpressure and occasional flushes
        for (int i = 0; i < 600; i++) begin
            @(posedge clk);
            #1;
            in_valid  = ($urandom_range(0, 3) != 0);
            a_in      = {rpix(), rpix()};
            b_in      = {rpix(), rpix()};
            out_ready = ($urandom_range(0, 9) < 7);
            win_clr   = ($urandom_range(0, 39) == 0);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        win_clr   = 1'b0;
        out_ready = 1'b1;
        idle(6);

        // Reset mid-stream
        send(300, 100, 100, 300);
        drive(11, 22, 33, 44);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 0);
        check("mid_rst_diff", 32'(diff_out), 0);
        check("mid_rst_sad", 32'(sad_out), 0);
        check("mid_rst_last", 32'(sad_last), 0);
        in_valid = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) send(int'(rpix()), int'(rpix()), int'(rpix()), int'(rpix()));
        idle(6);
        check("drain_empty", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
